// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: widths, FSM states
// and the saturation values used on overflow and divide-by-zero.
package div_pkg;

    localparam int NW = 16;
    localparam int DW = 7;
    localparam int CW = $clog2(NW);

    localparam logic [NW-1:0] QMAX = {1'b0, {(NW-1){1'b1}}};
    localparam logic [NW-1:0] QMIN = {1'b1, {(NW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes: shift in a dividend bit,
// trial-subtract the divisor, and emit the quotient bit.
module div_step #(
    parameter int DW = 7
) (
    input  logic [DW:0]   rem_i,
    input  logic          bit_i,
    input  logic [DW-1:0] dmag_i,
    output logic [DW:0]   rem_o,
    output logic          q_o
);

    logic [DW+1:0] remp;

    // rem_i < dmag_i on entry, so the shifted value always fits in DW+1 bits.
    always_comb begin
        remp  = {rem_i, bit_i};
        q_o   = (remp >= {2'b00, dmag_i});
        rem_o = q_o ? (DW+1)'(remp - {2'b00, dmag_i}) : (DW+1)'(remp);
    end

endmodule

// File: rtl/booth_div.sv
// Sequential signed divider: one quotient bit per clock on magnitudes,
// followed by a sign fix and saturation in the DONE cycle.
module booth_div
    import div_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [NW-1:0] N,
    input  logic signed [DW-1:0] D,
    output logic signed [NW-1:0] Q,
    output logic signed [DW-1:0] R,
    output logic                 valid,
    output logic                 busy,
    output logic                 div_by_zero,
    output logic                 overflow
);

    state_t        state_q;
    logic [NW-1:0] qsh_q;
    logic [DW:0]   rem_q;
    logic [DW-1:0] dmag_q;
    logic [CW-1:0] cnt_q;
    logic          sq_q, sr_q, dz_q;

    logic signed [NW-1:0] q_q;
    logic signed [DW-1:0] r_q;
    logic                 valid_q, busy_q, dbz_q, ovf_q;

    logic [DW:0]          step_rem;
    logic                 step_q;
    logic signed [NW-1:0] q_d;
    logic signed [DW-1:0] r_d;
    logic                 ovf_d;

    div_step #(.DW(DW)) u_step (
        .rem_i  (rem_q),
        .bit_i  (qsh_q[NW-1]),
        .dmag_i (dmag_q),
        .rem_o  (step_rem),
        .q_o    (step_q)
    );

    // Result formatting; only consumed in DONE, once qsh_q holds the quotient magnitude.
    always_comb begin
        ovf_d = !dz_q && !sq_q && (qsh_q == QMIN);
        q_d   = sq_q ? -qsh_q : qsh_q;
        r_d   = DW'(sr_q ? -rem_q : rem_q);
        if (dz_q) begin
            q_d = sr_q ? QMIN : QMAX;
            r_d = '0;
        end else if (ovf_d) begin
            q_d = QMAX;
            r_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            qsh_q   <= '0;
            rem_q   <= '0;
            dmag_q  <= '0;
            cnt_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            dz_q    <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (start) begin
                        qsh_q   <= N[NW-1] ? NW'(-N) : NW'(N);
                        dmag_q  <= D[DW-1] ? DW'(-D) : DW'(D);
                        sq_q    <= N[NW-1] ^ D[DW-1];
                        sr_q    <= N[NW-1];
                        dz_q    <= (D == '0);
                        rem_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= (D == '0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    qsh_q <= {qsh_q[NW-2:0], step_q};
                    rem_q <= step_rem;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(NW-1))
                        state_q <= DONE;
                end
                DONE: begin
                    q_q     <= q_d;
                    r_q     <= r_d;
                    dbz_q   <= dz_q;
                    ovf_q   <= ovf_d;
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Q           = q_q;
    assign R           = r_q;
    assign valid       = valid_q;
    assign busy        = busy_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_booth_div.sv
// Bench for booth_div: directed vectors, an arithmetic reference model with a
// per-cycle result/timing compare, and literal pins on the held outputs.
module tb_booth_div;

    logic               clk, rst, start;
    logic signed [15:0] N, Q;
    logic signed [6:0]  D, R;
    logic               valid, busy, div_by_zero, overflow;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int n;
        int d;
        int due;
    } op_t;
    op_t sb[$];

    booth_div dut (
        .clk(clk), .rst(rst), .start(start), .N(N), .D(D),
        .Q(Q), .R(R), .valid(valid), .busy(busy),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: truncating signed division with the block's saturation rules.
    function automatic void model(input int n, input int d, output int q, output int r,
                                  output int dz, output int ov);
        dz = 0; ov = 0;
        if (d == 0) begin
            dz = 1; q = (n < 0) ? -32768 : 32767; r = 0;
        end else if (n == -32768 && d == -1) begin
            ov = 1; q = 32767; r = 0;
        end else begin
            q = n / d; r = n % d;
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            bit exp_v;
            int q, r, dz, ov;
            exp_v = (sb.size() > 0) && (sb[0].due == cyc);
            chk("valid", int'(valid), int'(exp_v));
            if (exp_v) begin
                model(sb[0].n, sb[0].d, q, r, dz, ov);
                chk("Q", int'(Q), q);
                chk("R", int'(R), r);
                chk("div_by_zero", int'(div_by_zero), dz);
                chk("overflow", int'(overflow), ov);
                void'(sb.pop_front());
            end else if (sb.size() > 0 && sb[0].due < cyc) begin
                void'(sb.pop_front());
            end
        end
    end

    task automatic push(input logic signed [15:0] n, input logic signed [6:0] d, input int c0);
        op_t o;
        o.n = int'(n); o.d = int'(d);
        o.due = c0 + ((d == 0) ? 1 : 17);
        sb.push_back(o);
    endtask

    // Start one operation, scramble inputs after acceptance, count busy cycles.
    task automatic run(input logic signed [15:0] n, input logic signed [6:0] d, output int bc);
        int lat;
        lat = (d == 0) ? 1 : 17;
        bc = 0;
        @(negedge clk);
        N = n; D = d; start = 1'b1;
        @(posedge clk); #1;
        push(n, d, cyc);
        start = 1'b0;
        N = 16'($urandom); D = 7'($urandom);
        for (int i = 0; i < lat + 4; i++) begin
            @(negedge clk);
            bc += int'(busy);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_Q"}, int'(Q), 0);
        chk({tag, "_R"}, int'(R), 0);
        chk({tag, "_valid"}, int'(valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_dbz"}, int'(div_by_zero), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
    endtask

    logic signed [15:0] vn [10] = '{100, -100, 100, -100, -32768, -32768, 5, -5, 32767, -1};
    logic signed [6:0]  vd [10] = '{7, 7, -7, -7, -1, -64, 0, 0, 1, 63};
    int vq   [10] = '{14, -14, -14, 14, 32767, 512, 32767, -32768, 32767, 0};
    int vr   [10] = '{2, -2, 2, -2, 0, 0, 0, 0, 0, -1};
    int vov  [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    int vdz  [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
    int vbsy [10] = '{18, 18, 18, 18, 18, 18, 2, 2, 18, 18};

    initial begin
        int bc, c0;
        rst = 1'b0; start = 1'b0; N = '0; D = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        #2 rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run(vn[i], vd[i], bc);
            chk("busy_cycles", bc, vbsy[i]);
            chk("held_Q", int'(Q), vq[i]);
            chk("held_R", int'(R), vr[i]);
            chk("held_ovf", int'(overflow), vov[i]);
            chk("held_dbz", int'(div_by_zero), vdz[i]);
        end

        // Start pulsed mid-operation must be dropped.
        @(negedge clk);
        N = 16'sd1000; D = 7'sd7; start = 1'b1;
        @(posedge clk); #1;
        push(16'sd1000, 7'sd7, cyc);
        start = 1'b0;
        repeat (4) @(negedge clk);
        N = 16'sd9; D = 7'sd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("ignored_Q", int'(Q), 142);
        chk("ignored_R", int'(R), 6);

        // Start held through DONE: second op accepted NW+2 cycles after the first.
        @(negedge clk);
        N = 16'sd200; D = 7'sd9; start = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        push(16'sd200, 7'sd9, c0);
        push(16'sd200, 7'sd9, c0 + 18);
        while (cyc < c0 + 18) @(posedge clk);
        #1 start = 1'b0;
        repeat (25) @(negedge clk);
        chk("b2b_Q", int'(Q), 22);
        chk("b2b_R", int'(R), 2);

        // Reset mid-operation aborts with no result.
        @(negedge clk);
        N = 16'sd1234; D = 7'sd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst = 1'b0;
        sb.delete();
        #1 chk_zero("abort");
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (25) @(negedge clk);
        chk("abort_quiet_valid", int'(valid), 0);
        chk("abort_quiet_Q", int'(Q), 0);

        run(16'sd63, 7'sd8, bc);
        chk("fresh_Q", int'(Q), 7);
        chk("fresh_R", int'(R), 7);
        chk("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
